guard_reset_ctrl: RTL and testbench

Sequences slave recovery after a guard timeout. It collects reset requests from the read and write guards, isolates the slave port, and drains or abandons outstanding transactions. It then drives a timed slave reset, returns `reset_clear` to both guards, and holds an interrupt until software acknowledges. It sits between the read/write guards, the bus isolation stage and the slave reset domain.

---
 rtl/guard_reset_ctrl_if.sv | 28 ++
 rtl/guard_reset_ctrl.sv | 120 ++++++++++++
 tb/tb_guard_reset_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/guard_reset_ctrl_if.sv
// Signal bundle between the read/write guards, software ack and the recovery sequencer.
// Requests are levels held by the guards until reset_clear_o; sw_ack_i and reset_clear_o are one-cycle pulses.
interface guard_reset_ctrl_if #(
    parameter int CntWidth = 8
);
    logic                rd_reset_req_i;
    logic                wr_reset_req_i;
    logic                outstanding_i;
    logic                sw_ack_i;
    logic                isolate_o;
    logic                slv_rst_o;
    logic                reset_clear_o;
    logic                irq_o;
    logic                busy_o;
    logic [2:0]          state_o;
    logic [2:0]          cause_o;
    logic [CntWidth-1:0] reset_count_o;

    modport master (
        output rd_reset_req_i, wr_reset_req_i, outstanding_i, sw_ack_i,
        input  isolate_o, slv_rst_o, reset_clear_o, irq_o, busy_o, state_o, cause_o, reset_count_o
    );

    modport slave (
        input  rd_reset_req_i, wr_reset_req_i, outstanding_i, sw_ack_i,
        output isolate_o, slv_rst_o, reset_clear_o, irq_o, busy_o, state_o, cause_o, reset_count_o
    );
endinterface

// File: rtl/guard_reset_ctrl.sv
// Slave recovery sequencer: isolate, drain (bounded), timed slave reset, clear pulse to guards,
// then interrupt held until software acknowledges. Moore machine; outputs come from registers only.
module guard_reset_ctrl #(
    parameter int HoldCycles   = 16,
    parameter int DrainTimeout = 256,
    parameter int CntWidth     = 8
) (
    input logic               clk_i,
    input logic               rst_i,
    guard_reset_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISOLATE  = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_RESET    = 3'd3,
        ST_CLEAR    = 3'd4,
        ST_WAIT_ACK = 3'd5
    } state_t;

    localparam int DrainW = $clog2(DrainTimeout + 1);
    localparam int HoldW  = $clog2(HoldCycles + 1);
    localparam logic [DrainW-1:0] DrainLast = DrainW'(DrainTimeout - 1);
    localparam logic [HoldW-1:0]  HoldLoad  = HoldW'(HoldCycles - 1);

    state_t              state_q;
    state_t              state_d;
    logic [DrainW-1:0]   drain_cnt;
    logic [HoldW-1:0]    hold_cnt;
    logic [2:0]          cause;
    logic [CntWidth-1:0] reset_count;
    logic                req_any;

    assign req_any = bus.rd_reset_req_i | bus.wr_reset_req_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (req_any) state_d = ST_ISOLATE;
            ST_ISOLATE:  state_d = ST_DRAIN;
            ST_DRAIN:    if (!bus.outstanding_i || drain_cnt == DrainLast) state_d = ST_RESET;
            ST_RESET:    if (hold_cnt == '0) state_d = ST_CLEAR;
            ST_CLEAR:    state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: if (bus.sw_ack_i) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Cause accumulates requests until the slave reset finishes; a clean drain exit wins over timeout.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drain_cnt   <= '0;
            hold_cnt    <= '0;
            cause       <= '0;
            reset_count <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_any) cause <= {1'b0, bus.wr_reset_req_i, bus.rd_reset_req_i};
                end
                ST_ISOLATE: begin
                    cause[1:0] <= cause[1:0] | {bus.wr_reset_req_i, bus.rd_reset_req_i};
                    drain_cnt  <= '0;
                end
                ST_DRAIN: begin
                    cause[1:0] <= cause[1:0] | {bus.wr_reset_req_i, bus.rd_reset_req_i};
                    if (bus.outstanding_i) begin
                        if (drain_cnt == DrainLast) cause[2] <= 1'b1;
                        else drain_cnt <= drain_cnt + DrainW'(1);
                    end
                    if (state_d == ST_RESET) begin
                        hold_cnt <= HoldLoad;
                        if (reset_count != '1) reset_count <= reset_count + CntWidth'(1);
                    end
                end
                ST_RESET: begin
                    cause[1:0] <= cause[1:0] | {bus.wr_reset_req_i, bus.rd_reset_req_i};
                    if (hold_cnt != '0) hold_cnt <= hold_cnt - HoldW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        bus.isolate_o     = 1'b0;
        bus.slv_rst_o     = 1'b0;
        bus.reset_clear_o = 1'b0;
        bus.irq_o         = 1'b0;
        bus.busy_o        = (state_q != ST_IDLE);
        case (state_q)
            ST_ISOLATE:  bus.isolate_o = 1'b1;
            ST_DRAIN:    bus.isolate_o = 1'b1;
            ST_RESET: begin
                bus.isolate_o = 1'b1;
                bus.slv_rst_o = 1'b1;
            end
            ST_CLEAR: begin
                bus.isolate_o     = 1'b1;
                bus.reset_clear_o = 1'b1;
            end
            ST_WAIT_ACK: bus.irq_o = 1'b1;
            default: begin
            end
        endcase
    end

    assign bus.state_o       = state_q;
    assign bus.cause_o       = cause;
    assign bus.reset_count_o = reset_count;
endmodule

// File: tb/tb_guard_reset_ctrl.sv
// Directed bench for guard_reset_ctrl: each clear pulse is checked against a queued expectation
// of {cause, count, slave-reset length, isolate-to-clear latency}.
module tb_guard_reset_ctrl;
    localparam int HoldCycles   = 16;
    localparam int DrainTimeout = 256;
    localparam int CntWidth     = 2;
    localparam int CntMax       = 3;
    localparam int W            = 3 + CntWidth + 16 + 16;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    guard_reset_ctrl_if #(.CntWidth(CntWidth)) bus ();

    guard_reset_ctrl #(
        .HoldCycles  (HoldCycles),
        .DrainTimeout(DrainTimeout),
        .CntWidth    (CntWidth)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    logic [W-1:0] exp_q[$];
    int n_checks  = 0;
    int n_fail    = 0;
    int exp_count = 0;

    logic [1:0] req_tab[5]   = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b11};
    int         count_tab[5] = '{1, 2, 3, 3, 3};

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard monitor
    int           sample_idx = 0;
    int           iso_start  = 0;
    int           rst_len    = 0;
    logic         prev_iso   = 1'b0;
    logic [W-1:0] got_v;
    logic [W-1:0] exp_v;

    always @(negedge clk) begin
        if (rst) begin
            rst_len  = 0;
            prev_iso = 1'b0;
        end else begin
            sample_idx++;
            if (bus.isolate_o && !prev_iso) iso_start = sample_idx;
            prev_iso = bus.isolate_o;
            if (bus.slv_rst_o) rst_len++;
            if (bus.reset_clear_o) begin
                got_v = {bus.cause_o, bus.reset_count_o, 16'(rst_len), 16'(sample_idx - iso_start)};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_clear: got clear pulse cause=%b cnt=%0d, required none",
                             bus.cause_o, bus.reset_count_o);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (got_v !== exp_v) begin
                        n_fail++;
                        $display("FAIL clear_event: got cause=%b cnt=%0d hold=%0d lat=%0d, required cause=%b cnt=%0d hold=%0d lat=%0d",
                                 got_v[W-1 -: 3], got_v[32 +: CntWidth], got_v[31:16], got_v[15:0],
                                 exp_v[W-1 -: 3], exp_v[32 +: CntWidth], exp_v[31:16], exp_v[15:0]);
                    end
                end
                rst_len = 0;
            end
        end
    end

    // driver tasks
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string name);
        for (int i = 0; i < budget && bus.state_o != st; i++) tick(1);
        check(name, 32'(bus.state_o), 32'(st));
    endtask

    task automatic push_exp(input logic [2:0] cause, input int cnt, input int lat);
        logic [CntWidth-1:0] c;
        c = CntWidth'(cnt);
        exp_q.push_back({cause, c, 16'(HoldCycles), 16'(lat)});
    endtask

    task automatic bump_count();
        exp_count = (exp_count >= CntMax) ? CntMax : exp_count + 1;
    endtask

    task automatic do_ack();
        bus.sw_ack_i = 1'b1;
        tick(1);
        bus.sw_ack_i = 1'b0;
        check("ack_state", 32'(bus.state_o), 32'd0);
        check("ack_irq", 32'(bus.irq_o), 32'd0);
        check("ack_busy", 32'(bus.busy_o), 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_outs"}, 32'({bus.isolate_o, bus.slv_rst_o, bus.reset_clear_o, bus.irq_o, bus.busy_o}), 32'd0);
        check({name, "_state"}, 32'(bus.state_o), 32'd0);
        check({name, "_cause"}, 32'(bus.cause_o), 32'd0);
        check({name, "_count"}, 32'(bus.reset_count_o), 32'd0);
    endtask

    // drain_hi: DRAIN cycles with outstanding_i held high before it drops
    task automatic run_seq(input logic [1:0] req, input int drain_hi, input logic [2:0] exp_cause, input int lat);
        bump_count();
        push_exp(exp_cause, exp_count, lat);
        bus.rd_reset_req_i = req[0];
        bus.wr_reset_req_i = req[1];
        bus.outstanding_i  = (drain_hi > 0);
        tick(1);
        check("isolate_state", 32'(bus.state_o), 32'd1);
        check("isolate_o", 32'(bus.isolate_o), 32'd1);
        tick(1);
        check("drain_state", 32'(bus.state_o), 32'd2);
        tick(drain_hi);
        bus.outstanding_i  = 1'b0;
        bus.rd_reset_req_i = 1'b0;
        bus.wr_reset_req_i = 1'b0;
        wait_state(3'd3, 2, "reach_reset");
        wait_state(3'd5, HoldCycles + 4, "reach_wait_ack");
        check("wait_irq", 32'(bus.irq_o), 32'd1);
        check("wait_isolate", 32'(bus.isolate_o), 32'd0);
        check("seq_cause", 32'(bus.cause_o), 32'(exp_cause));
        check("seq_count", 32'(bus.reset_count_o), 32'(exp_count));
        do_ack();
    endtask

    initial begin
        bus.rd_reset_req_i = 1'b0;
        bus.wr_reset_req_i = 1'b0;
        bus.outstanding_i  = 1'b0;
        bus.sw_ack_i       = 1'b0;
        tick(3);
        check_all_zero("reset");
        rst = 1'b0;
        tick(2);
        check_all_zero("idle");

        // read request, nothing outstanding
        run_seq(2'b01, 0, 3'b001, HoldCycles + 2);
        // write request, 5 busy DRAIN cycles
        run_seq(2'b10, 5, 3'b010, HoldCycles + 7);
        // outstanding stuck: full drain timeout
        run_seq(2'b10, DrainTimeout, 3'b110, HoldCycles + DrainTimeout + 1);

        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_count = 0;
        check("count_after_rst", 32'(bus.reset_count_o), 32'd0);

        // read at t, write joins during RESET; sw_ack there is ignored
        exp_count = 1;
        push_exp(3'b011, 1, HoldCycles + 2);
        bus.rd_reset_req_i = 1'b1;
        tick(1);
        check("merge_isolate", 32'(bus.isolate_o), 32'd1);
        wait_state(3'd3, 4, "merge_reset");
        bus.rd_reset_req_i = 1'b0;
        bus.wr_reset_req_i = 1'b1;
        bus.sw_ack_i       = 1'b1;
        tick(1);
        bus.sw_ack_i = 1'b0;
        check("ack_ignored", 32'(bus.state_o), 32'd3);
        wait_state(3'd5, HoldCycles + 4, "merge_wait_ack");
        check("merge_cause", 32'(bus.cause_o), 32'd3);
        check("merge_count", 32'(bus.reset_count_o), 32'd1);
        exp_count = 2;
        push_exp(3'b010, 2, HoldCycles + 2);
        bus.sw_ack_i = 1'b1;
        tick(1);
        bus.sw_ack_i = 1'b0;
        check("held_ack_state", 32'(bus.state_o), 32'd0);
        check("held_ack_irq", 32'(bus.irq_o), 32'd0);
        tick(1);
        check("restart_state", 32'(bus.state_o), 32'd1);
        check("restart_isolate", 32'(bus.isolate_o), 32'd1);
        bus.wr_reset_req_i = 1'b0;
        wait_state(3'd5, HoldCycles + 8, "restart_wait_ack");
        check("restart_cause", 32'(bus.cause_o), 32'd2);
        check("restart_count", 32'(bus.reset_count_o), 32'd2);
        do_ack();

        // asynchronous abort mid-RESET: no clear pulse expected
        bus.rd_reset_req_i = 1'b1;
        wait_state(3'd3, 4, "abort_reset");
        bus.rd_reset_req_i = 1'b0;
        tick(5);
        check("abort_slv_rst", 32'(bus.slv_rst_o), 32'd1);
        rst = 1'b1;
        tick(1);
        check_all_zero("abort_in_rst");
        rst = 1'b0;
        tick(1);
        check_all_zero("abort_after");
        tick(HoldCycles + 8);
        exp_count = 0;

        // saturation with a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            run_seq(req_tab[i], 0, {1'b0, req_tab[i]}, HoldCycles + 2);
            check("count_tab", 32'(bus.reset_count_o), 32'(count_tab[i]));
        end

        tick(2);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
